// File: rtl/regfile_dump.sv
// Walks the register file debug port from FIRST_REG to LAST_REG and streams
// each captured 32-bit word out as four bytes, MSB first, over valid/ready.
module regfile_dump #(
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_abort,
  output logic [4:0]  o_test_addr,
  input  logic [31:0] i_test_data,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  output logic        o_busy,
  output logic        o_done
);

  localparam logic [4:0] FIRST_ADDR = 5'(FIRST_REG);
  localparam logic [4:0] LAST_ADDR  = 5'(LAST_REG);

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    CAPTURE,
    SEND,
    DONE
  } state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic [31:0] r_shadow;
  logic [1:0]  r_byteIdx;
  logic [4:0]  r_testAddr;
  logic        w_accept;
  logic        w_lastByte;
  logic        w_lastReg;

  assign w_accept   = (r_state == SEND) && i_tx_ready;
  assign w_lastByte = (r_byteIdx == 2'd3);
  assign w_lastReg  = (r_testAddr == LAST_ADDR);

  // Abort overrides every transition, which also keeps start from launching in IDLE
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (i_start) w_nextState = SETTLE;
      SETTLE:  w_nextState = CAPTURE;
      CAPTURE: w_nextState = SEND;
      SEND: begin
        if (w_accept && w_lastByte) begin
          w_nextState = w_lastReg ? DONE : SETTLE;
        end
      end
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
    if (i_abort) begin
      w_nextState = IDLE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_testAddr <= FIRST_ADDR;
      r_shadow   <= '0;
      r_byteIdx  <= '0;
    end else begin
      r_state <= w_nextState;
      if (!i_abort) begin
        case (r_state)
          IDLE: begin
            if (i_start) begin
              r_testAddr <= FIRST_ADDR;
              r_byteIdx  <= '0;
            end
          end
          CAPTURE: r_shadow <= i_test_data;
          SEND: begin
            if (w_accept) begin
              if (!w_lastByte) begin
                r_byteIdx <= r_byteIdx + 2'd1;
              end else if (!w_lastReg) begin
                r_testAddr <= r_testAddr + 5'd1;
                r_byteIdx  <= '0;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    o_tx_data = r_shadow[31:24];
    case (r_byteIdx)
      2'd0: o_tx_data = r_shadow[31:24];
      2'd1: o_tx_data = r_shadow[23:16];
      2'd2: o_tx_data = r_shadow[15:8];
      2'd3: o_tx_data = r_shadow[7:0];
      default: o_tx_data = r_shadow[31:24];
    endcase
  end

  assign o_test_addr = r_testAddr;
  assign o_tx_valid  = (r_state == SEND);
  assign o_busy      = (r_state != IDLE);
  assign o_done      = (r_state == DONE);

endmodule

// File: tb/tb_regfile_dump.sv
// Randomised bench for regfile_dump: a regfile array feeds the DUT and a
// byte queue built straight from the register contents predicts the stream.
module tb_regfile_dump;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic        ready;
  logic [31:0] rf [32];

  logic [4:0]  addrA, addrB;
  logic [31:0] tdA, tdB;
  logic [7:0]  dataA, dataB;
  logic        validA, validB, busyA, busyB, doneA, doneB;

  int          sel;
  logic [4:0]  oAddr;
  logic [7:0]  oData;
  logic        oValid, oBusy, oDone;

  int vectors = 0;
  int misses  = 0;

  always #5 clk = ~clk;

  assign tdA = rf[addrA];
  assign tdB = rf[addrB];

  regfile_dump dutA (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort),
    .o_test_addr(addrA), .i_test_data(tdA), .o_tx_data(dataA),
    .o_tx_valid(validA), .i_tx_ready(ready), .o_busy(busyA), .o_done(doneA)
  );

  regfile_dump #(.FIRST_REG(7), .LAST_REG(7)) dutB (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort),
    .o_test_addr(addrB), .i_test_data(tdB), .o_tx_data(dataB),
    .o_tx_valid(validB), .i_tx_ready(ready), .o_busy(busyB), .o_done(doneB)
  );

  always_comb begin
    if (sel == 1) begin
      oAddr = addrB; oData = dataB; oValid = validB; oBusy = busyB; oDone = doneB;
    end else begin
      oAddr = addrA; oData = dataA; oValid = validA; oBusy = busyA; oDone = doneA;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      misses++;
      $display("[TB] FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic checkReset(input int first);
    checkOutput("rstValid", 32'(oValid), 0);
    checkOutput("rstBusy", 32'(oBusy), 0);
    checkOutput("rstDone", 32'(oDone), 0);
    checkOutput("rstAddr", 32'(oAddr), 32'(first));
    checkOutput("rstData", 32'(oData), 0);
  endtask

  task automatic applyReset(input int first);
    @(negedge clk);
    rst = 1'b1; start = 1'b0; abort = 1'b0; ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    checkReset(first);
  endtask

  // mode: 0 ready held high, 1 ready toggling, 2 ready random
  task automatic applyStimulus(input int s, input int mode, input int first, input int last,
                               input int abortAfter, input int wrAfter, input int wrReg,
                               input logic [31:0] wrVal, input int startAgain, input int rstAt);
    logic [7:0] q[$];
    int         n;
    int         acc;
    bit         fin;
    bit         firstSeen;
    bit         sawDone;
    logic       pValid, pReady;
    logic [7:0] pData;
    logic [31:0] w;

    sel = s;
    for (int r = first; r <= last; r++) begin
      w = rf[r];
      q.push_back(w[31:24]);
      q.push_back(w[23:16]);
      q.push_back(w[15:8]);
      q.push_back(w[7:0]);
    end

    @(negedge clk);
    start = 1'b1; abort = 1'b0; ready = 1'b0;
    n = 0; acc = 0; fin = 0; firstSeen = 0;
    pValid = 1'b0; pReady = 1'b0; pData = '0;

    while (!fin && n < 2000) begin
      @(negedge clk);
      start = 1'b0; abort = 1'b0; n++;
      if (n == 1) checkOutput("addrFirst", 32'(oAddr), 32'(first));
      if (pValid && !pReady) checkOutput("hold", {23'b0, oValid, oData}, {23'b0, 1'b1, pData});
      if (oValid && !firstSeen) begin
        firstSeen = 1;
        checkOutput("latency", n, 3);
      end
      if (oDone) begin
        checkOutput("doneEarly", q.size(), 0);
        if (mode == 0) checkOutput("doneCycle", n, 6 * (last - first + 1) + 1);
        checkOutput("addrLast", 32'(oAddr), 32'(last));
        @(negedge clk);
        checkOutput("donePulse", {29'b0, oDone, oBusy, oValid}, 0);
        fin = 1;
      end else if (rstAt == n) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkReset(first);
        sawDone = 0;
        ready = 1'b1;
        repeat (250) begin
          @(negedge clk);
          if (oDone || oBusy) sawDone = 1;
        end
        checkOutput("quietAfterRst", 32'(sawDone), 0);
        fin = 1;
      end else begin
        checkOutput("busy", 32'(oBusy), 1);
        if (n == startAgain) start = 1'b1;
        if (mode == 0) ready = 1'b1;
        else if (mode == 1) ready = (n % 2 == 0);
        else ready = 1'($urandom_range(0, 1));
        if (abortAfter >= 0 && acc == abortAfter && oValid) begin
          abort = 1'b1; ready = 1'b0;
          @(negedge clk);
          abort = 1'b0;
          checkOutput("abortState", {29'b0, oValid, oBusy, oDone}, 0);
          checkOutput("abortAddr", 32'(oAddr), 32'(first + abortAfter / 4));
          sawDone = 0;
          repeat (20) begin
            @(negedge clk);
            if (oDone) sawDone = 1;
          end
          checkOutput("noDoneAfterAbort", 32'(sawDone), 0);
          fin = 1;
        end else if (oValid && ready) begin
          if (q.size() == 0) checkOutput("extraByte", 1, 0);
          else checkOutput("byte", 32'(oData), 32'(q.pop_front()));
          acc++;
          if (acc == wrAfter) rf[wrReg] = wrVal;
        end
        pValid = oValid; pReady = ready; pData = oData;
      end
    end
    if (!fin) checkOutput("timeout", 0, 1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; ready = 1'b0; sel = 0;
    for (int i = 0; i < 32; i++) rf[i] = 32'h0101_0101 * i;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkReset(0);

    // Full ramp dump with ready held high
    applyStimulus(0, 0, 0, 31, -1, -1, 0, 0, -1, -1);

    // DEADBEEF with toggling ready
    applyReset(0);
    rf[5] = 32'hDEAD_BEEF;
    applyStimulus(0, 1, 0, 31, -1, -1, 0, 0, -1, -1);

    // Write to r3 after its capture must not change the emitted word
    applyReset(0);
    rf[3] = 32'hCAFE_F00D;
    applyStimulus(0, 2, 0, 31, -1, 13, 3, 32'h1234_5678, -1, -1);

    // Abort mid r10, then restart without reset
    applyReset(0);
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    applyStimulus(0, 2, 0, 31, 42, -1, 0, 0, -1, -1);
    applyStimulus(0, 2, 0, 31, -1, -1, 0, 0, -1, -1);

    // Start while busy is ignored; mid-dump reset
    applyReset(0);
    applyStimulus(0, 2, 0, 31, -1, -1, 0, 0, 20, 60);
    applyReset(0);
    applyStimulus(0, 2, 0, 31, -1, -1, 0, 0, 20, -1);

    // Single-register instance
    sel = 1;
    applyReset(7);
    rf[7] = 32'hA5A5_5A5A;
    applyStimulus(1, 0, 7, 7, -1, -1, 0, 0, -1, -1);

    // Start and abort together in IDLE
    sel = 0;
    applyReset(0);
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    checkOutput("startAbortIdle", {30'b0, oBusy, oValid}, 0);

    // Random contents, random back-pressure
    for (int k = 0; k < 2; k++) begin
      applyReset(0);
      for (int i = 0; i < 32; i++) rf[i] = $urandom;
      applyStimulus(0, 2, 0, 31, -1, -1, 0, 0, -1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule

// File: doc/regfile_dump.md
Name: regfile_dump

Overview:
- Sequential reader for the CPU register file debug port: walks the register range, drives test_addr, captures test_data and streams each 32-bit value out as four bytes, MSB first, over a valid/ready byte interface.
- Sits between the register file's test port and a display/UART byte sink. Replaces manual single-register inspection with a full, ordered dump triggered by one pulse.

Parameters:
- FIRST_REG, 0, first register index dumped (0..31).
- LAST_REG, 31, last register index dumped (FIRST_REG..31).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  one-cycle request to begin a dump; sampled only in IDLE.
- abort  input  1  synchronous cancel; returns to IDLE without done.
- test_addr  output  5  register index presented to the register file test port (registered).
- test_data  input  32  combinational read data for test_addr.
- tx_data  output  8  byte being offered to the sink.
- tx_valid  output  1  tx_data valid.
- tx_ready  input  1  sink accepts byte when tx_valid & tx_ready at a rising edge.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse after the last byte of LAST_REG is accepted.

Behaviour:
- Reset values (rst=1 at edge): state IDLE, test_addr=FIRST_REG, shadow=0, byte_idx=0, tx_data=0, tx_valid=0, busy=0, done=0. rst has priority over abort and start.
- States: IDLE, SETTLE, CAPTURE, SEND, DONE.
- IDLE: tx_valid=0. start=1 -> test_addr<=FIRST_REG, byte_idx<=0, go SETTLE.
- SETTLE: one cycle for test_data to settle on the new address -> CAPTURE.
- CAPTURE: shadow<=test_data -> SEND. Later register-file writes do not change the bytes of this word.
- SEND: tx_valid=1, tx_data=shadow[31-8*byte_idx -: 8]. tx_data is stable while tx_valid=1 and tx_ready=0.
  - On accept with byte_idx<3: byte_idx+1.
  - On accept with byte_idx=3 and test_addr!=LAST_REG: test_addr+1, byte_idx<=0, go SETTLE.
  - On accept with byte_idx=3 and test_addr==LAST_REG: go DONE.
- DONE: done=1 for exactly one cycle, tx_valid=0 -> IDLE. test_addr holds LAST_REG until the next start.
- Latency: start sampled at edge E0 gives first tx_valid=1 in the cycle after edge E2. With tx_ready held high, each register takes 6 cycles. A full 0..31 dump is 192 cycles from start to last accept, then done in the next cycle.
- start while busy: ignored, no restart and no queuing.
- abort=1 in any non-IDLE state: next state IDLE, tx_valid=0, done stays 0, test_addr unchanged. A partially sent word is truncated; the sink resynchronises by the absence of done.
- start and abort together in IDLE: abort wins, stay IDLE.
- FIRST_REG==LAST_REG: exactly one word (4 bytes) then done.
- No wrap-around: test_addr never advances past LAST_REG.
- tx_ready is ignored when tx_valid=0.

Test Plan:
- Regfile preloaded rf[n]=32'h0101_0101*n, FIRST=0, LAST=31, tx_ready=1, start pulse -> 128 bytes: 00,00,00,00,01,01,01,01,...,1F,1F,1F,1F; done pulses once at cycle 193 after start; busy low afterwards.
- rf[5]=32'hDEADBEEF, tx_ready toggling 1-0-1-0 -> bytes DE,AD,BE,EF in order; tx_data stable across every ready=0 cycle; no byte duplicated or dropped.
- During SEND of r3, write rf[3]=32'h12345678 (old value 32'hCAFEF00D) -> dump emits CA,FE,F0,0D for r3 (snapshot held).
- abort asserted while sending byte 2 of r10 -> next cycle tx_valid=0, busy=0, done never asserted. A new start then restarts from FIRST_REG.
- Second start pulse at cycle 20 of a dump, and rst=1 pulse mid-dump -> second start has no effect. After rst: all outputs at reset values, test_addr=FIRST_REG, no done.
- FIRST_REG=LAST_REG=7, rf[7]=32'hA5A5_5A5A -> exactly A5,A5,5A,5A, then done.
